// File: rtl/pipe_mux.sv
// pipe_mux: registered N-to-1 channel multiplexer with valid/ready handshakes.
// The selected channel is captured into an output register. A one-entry skid
// register absorbs the word accepted in the cycle the output stalls, so
// in_ready can be a flop without losing throughput.
// Optional feature macro: PIPE_MUX_SEL_ERR_EN adds the sticky out-of-range
// select flag (sel_err), a saturating error counter (err_cnt) and its clear
// input (err_clr).
module pipe_mux #(
  parameter int WIDTH_DATA = 32,
  parameter int NUM_IN     = 12,
  localparam int SEL_W     = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*WIDTH_DATA-1:0] in_data,
  input  logic [SEL_W-1:0]             in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH_DATA-1:0]        out_data,
  output logic                         out_valid,
`ifdef PIPE_MUX_SEL_ERR_EN
  output logic                         sel_err,
  output logic [7:0]                   err_cnt,
  input  logic                         err_clr,
`endif
  input  logic                         out_ready
);

  localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_DATA-1:0]   out_data_q, out_data_d;
  logic [WIDTH_DATA-1:0]   skid_q, skid_d;
  logic                    in_ready_q, in_ready_d;
  logic [WIDTH_DATA-1:0]   mux_word;
  logic                    sel_bad;
  logic                    accept;
  logic                    xfer;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign xfer      = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign sel_bad   = ({1'b0, in_sel} >= NUM_IN_W);

  // Channel select; any select outside the channel range falls back to channel 0.
  always_comb begin
    mux_word = in_data[WIDTH_DATA-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (in_sel == k[SEL_W-1:0]) begin
        mux_word = in_data[k*WIDTH_DATA +: WIDTH_DATA];
      end
    end
  end

  // Occupancy FSM: decides where an accepted word lands and when the skid drains.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_ONE;
          out_data_d = mux_word;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_data_d = mux_word;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = mux_word;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d    = ST_ONE;
          out_data_d = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Ready is decided one cycle ahead from where the skid will be.
    in_ready_d = (state_d != ST_FULL);
  end

  // State, data and ready registers; reset empties the block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_MUX_SEL_ERR_EN
  logic       sel_err_q, sel_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_hit;

  assign err_hit = accept && sel_bad;
  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;

  // Error bookkeeping; a clear coinciding with a new error restarts the count at one.
  always_comb begin
    sel_err_d = sel_err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      sel_err_d = err_hit;
      err_cnt_d = err_hit ? 8'd1 : 8'd0;
    end else if (err_hit) begin
      sel_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // Error flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Directed testbench for pipe_mux (NUM_IN=12, WIDTH_DATA=32, channel k = 0x100+k).
// The error-counter checks are included when PIPE_MUX_SEL_ERR_EN is defined.
module tb_pipe_mux;

  localparam int WD = 32;
  localparam int NI = 12;
  localparam int SW = $clog2(NI);

  logic              clk;
  logic              rst_n;
  logic [NI*WD-1:0]  in_data;
  logic [SW-1:0]     in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [WD-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef PIPE_MUX_SEL_ERR_EN
  logic              sel_err;
  logic [7:0]        err_cnt;
  logic              err_clr;
`endif

  int checks = 0;
  int errors = 0;

  pipe_mux #(.WIDTH_DATA(WD), .NUM_IN(NI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef PIPE_MUX_SEL_ERR_EN
    .sel_err   (sel_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [SW-1:0] s;
    logic          ordy;
    logic          ev;
    logic [WD-1:0] ed;
    logic          er;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) in_data[k*WD +: WD] = 32'h100 + k;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef PIPE_MUX_SEL_ERR_EN
    err_clr   = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef PIPE_MUX_SEL_ERR_EN
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    #5 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    chk("valid_after_rst", {31'd0, out_valid}, 32'd0);

    // Table: single word, drain, out-of-range default, skid fill, stall hold,
    // skid drain, pass-through, out-of-range into skid, drain to empty.
    tbl[0] = '{1'b1, 4'd5,  1'b1, 1'b1, 32'h105, 1'b1};
    tbl[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 32'h105, 1'b1};
    tbl[2] = '{1'b1, 4'd14, 1'b0, 1'b1, 32'h100, 1'b1};
    tbl[3] = '{1'b1, 4'd1,  1'b0, 1'b1, 32'h100, 1'b0};
    tbl[4] = '{1'b1, 4'd2,  1'b0, 1'b1, 32'h100, 1'b0};
    tbl[5] = '{1'b0, 4'd0,  1'b1, 1'b1, 32'h101, 1'b1};
    tbl[6] = '{1'b1, 4'd11, 1'b1, 1'b1, 32'h10B, 1'b1};
    tbl[7] = '{1'b1, 4'd15, 1'b0, 1'b1, 32'h10B, 1'b0};
    tbl[8] = '{1'b0, 4'd0,  1'b1, 1'b1, 32'h100, 1'b1};
    tbl[9] = '{1'b0, 4'd0,  1'b1, 1'b0, 32'h100, 1'b1};
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].v;
      in_sel    = tbl[i].s;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
      if (tbl[i].ev) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
    end

    // Backpressure: sel 1,2 accepted, sel 3 held off until the skid drains.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 4'd1;
    tick();
    in_sel = 4'd2;
    tick();
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    in_sel = 4'd3;
    tick();
    chk("bp_hold_data", out_data, 32'h101);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_word", out_data, 32'h102);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_third_word", out_data, 32'h103);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: one word per cycle, select cycling through all channels.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sel = SW'(i % NI);
      tick();
      chk($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_data", i), out_data, 32'h100 + (i % NI));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while FULL: outputs clear at once, nothing stale follows.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 4'd7;
    tick();
    in_sel = 4'd8;
    tick();
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst%0d_valid", i), {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

`ifdef PIPE_MUX_SEL_ERR_EN
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 4'd14;
    tick();
    chk("err_data_ch0", out_data, 32'h100);
    chk("err_flag", {31'd0, sel_err}, 32'd1);
    chk("err_cnt_one", {24'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) tick();
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    in_valid = 1'b0;
    err_clr  = 1'b1;
    tick();
    chk("clr_flag", {31'd0, sel_err}, 32'd0);
    chk("clr_cnt", {24'd0, err_cnt}, 32'd0);
    in_valid = 1'b1;
    in_sel   = 4'd13;
    tick();
    chk("clr_hit_flag", {31'd0, sel_err}, 32'd1);
    chk("clr_hit_cnt", {24'd0, err_cnt}, 32'd1);
    err_clr = 1'b0;
    in_sel  = 4'd4;
    tick();
    chk("good_sel_no_err", {24'd0, err_cnt}, 32'd1);
    in_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 32: data width per input channel, in bits.
REQ-002 SHALL have parameter NUM_IN, default 12: number of input channels, from 2 to 16.
REQ-003 SHALL have local parameter SEL_W = ceil(log2(NUM_IN)): select width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  NUM_IN*WIDTH_DATA  flattened channels; channel k occupies bits [k*WIDTH_DATA +: WIDTH_DATA].
REQ-007 in_sel  input  SEL_W  channel select, sampled with in_valid.
REQ-008 in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-009 in_ready  output  1  block accepts this cycle; registered output.
REQ-010 out_data  output  WIDTH_DATA  selected channel data; registered output.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 sel_err  output  1  sticky out-of-range select flag; present only with PIPE_MUX_SEL_ERR_EN.
REQ-014 err_cnt  output  8  saturating error count; present only with PIPE_MUX_SEL_ERR_EN.
REQ-015 err_clr  input  1  synchronous clear of sel_err and err_cnt; present only with PIPE_MUX_SEL_ERR_EN.

Function
REQ-016 SHALL accept a word when in_valid && in_ready (input handshake).
REQ-017 SHALL transfer a word out when out_valid && out_ready (output handshake).
REQ-018 SHALL store in_data[in_sel] for an accepted word when in_sel < NUM_IN.
REQ-019 SHALL store channel 0 for an accepted word when in_sel >= NUM_IN (out-of-range default).
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N appears with out_valid=1 after edge N when the output register is empty or draining.
REQ-021 SHALL provide two storage stages: an output register and a one-entry skid register.
REQ-022 in_ready SHALL equal NOT skid_full, registered.
REQ-023 State SHALL be one of three: EMPTY (0 words), ONE (output register full), FULL (output register and skid both full).
REQ-024 EMPTY SHALL go to ONE on accept.
REQ-025 ONE SHALL stay in ONE on accept with simultaneous output transfer (pass-through).
REQ-026 ONE SHALL go to FULL on accept without output transfer (word goes to skid).
REQ-027 ONE SHALL go to EMPTY on output transfer without accept.
REQ-028 FULL SHALL go to ONE on output transfer (skid moves to output register); accept is impossible in FULL.
REQ-029 Words SHALL leave in acceptance order; no word is lost or duplicated.
REQ-030 Throughput SHALL be one word per cycle while out_ready stays 1.
REQ-031 out_data SHALL be held stable while out_valid=1 && out_ready=0.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force state EMPTY, out_valid=0, out_data=0, in_ready=0, skid contents=0, sel_err=0 and err_cnt=0.
REQ-033 in_ready SHALL rise to 1 on the first rising edge after rst_n deasserts.
REQ-034 Reset during operation SHALL discard all buffered words; none appears after reset.

Configuration
REQ-035 With PIPE_MUX_SEL_ERR_EN defined, each accepted word with in_sel >= NUM_IN SHALL set sel_err=1 and increment err_cnt, saturating at 255.
REQ-036 With PIPE_MUX_SEL_ERR_EN defined, err_clr=1 SHALL zero sel_err and err_cnt at the next edge; a simultaneous error SHALL leave sel_err=1 and err_cnt=1.
REQ-037 Without PIPE_MUX_SEL_ERR_EN, the ports sel_err, err_cnt and err_clr and their logic SHALL be absent; the out-of-range channel-0 default still applies.

Verification
REQ-038 Reset then NUM_IN=12, WIDTH_DATA=32, in_k=0x100+k, sel=5, one word -> out_valid=1 the next cycle with out_data=0x105.
REQ-039 out_ready=0, three offers with sel=1, 2, 3 -> first two accepted, in_ready=0 after the second; raise out_ready -> outputs 0x101 then 0x102, then in_ready=1 and 0x103 is accepted.
REQ-040 Continuous in_valid=1 and out_ready=1 for 20 cycles with sel cycling 0..11 -> 20 outputs in order, one per cycle, no bubbles.
REQ-041 PIPE_MUX_SEL_ERR_EN defined, sel=14 accepted -> out_data=0x100, sel_err=1, err_cnt=1; 300 more bad selects -> err_cnt=255; err_clr=1 -> both 0.
REQ-042 rst_n=0 asserted mid-cycle while in state FULL -> out_valid=0 immediately; after release, no stale word is output.
